// File: rtl/cmd_table_engine_if.sv
// Handshake and table-write bundle for cmd_table_engine.
// The master side drives commands and table writes. The slave side returns responses.
interface cmd_table_engine_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CMD_W  = 8
);
    localparam int AW = $clog2(DEPTH);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              result_ready;
    logic              err;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, cmd_valid, cmd, result_ready,
        input  cmd_ready, result, result_valid, err, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, cmd_valid, cmd, result_ready,
        output cmd_ready, result, result_valid, err, busy
    );
endinterface

// File: rtl/cmd_table_engine.sv
// Command engine built around a table and an accumulator.
// The engine executes READ, ACCUM and CLEAR commands and returns one response per accepted command.
//
// state     | meaning
// ----------|-------------------------------------------------------
// S_IDLE    | cmd_ready high; a NOP (cmd == 0) is consumed in place
// S_PROCESS | one cycle: table lookup, acc update, result capture
// S_DONE    | result_valid high; held until result_ready
module cmd_table_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CMD_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    cmd_table_engine_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = CMD_W - 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PROCESS = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_ACCUM = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    logic [DATA_W-1:0] r_table [DEPTH];
    logic [1:0]        r_state;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic              r_err;

    logic [1:0]        w_op;
    logic [IW-1:0]     w_idx;
    logic              w_idx_ok;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_entry;
    logic [DATA_W-1:0] w_sum;

    assign w_op  = r_cmd[CMD_W-1 -: 2];
    assign w_idx = r_cmd[IW-1:0];

    // Range checks exist only when the index field can address past the table.
    if ((1 << IW) == DEPTH) begin : g_idx_full
        assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
        assign w_idx_ok = (w_idx < IW'(DEPTH));
    end

    if ((1 << AW) == DEPTH) begin : g_wr_full
        assign w_wr_ok = 1'b1;
    end else begin : g_wr_part
        assign w_wr_ok = (bus.wr_addr < AW'(DEPTH));
    end

    assign w_entry = w_idx_ok ? r_table[w_idx[AW-1:0]] : '0;
    assign w_sum   = r_acc + w_entry;

    // The table is not reset. A same-cycle write is not visible to the PROCESS lookup.
    always_ff @(posedge clk) begin
        if (bus.wr_en && w_wr_ok) begin
            r_table[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cmd    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && (bus.cmd != '0)) begin
                        r_cmd   <= bus.cmd;
                        r_state <= S_PROCESS;
                    end
                end
                S_PROCESS: begin
                    r_state <= S_DONE;
                    if (!w_idx_ok || (w_op == 2'b11)) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else if (w_op == OP_READ) begin
                        r_result <= w_entry;
                        r_err    <= 1'b0;
                    end else if (w_op == OP_ACCUM) begin
                        r_acc    <= w_sum;
                        r_result <= w_sum;
                        r_err    <= 1'b0;
                    end else if (w_op == OP_CLEAR) begin
                        r_acc    <= '0;
                        r_result <= '0;
                        r_err    <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.result       = r_result;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_cmd_table_engine.sv
// Directed scoreboard bench for cmd_table_engine, built with DEPTH = 12.
// The driver pushes the expected responses. A negedge monitor pops them and compares on each handshake.
module tb_cmd_table_engine;
    localparam int DW    = 32;
    localparam int DEPTH = 12;
    localparam int CW    = 8;
    localparam int AW    = $clog2(DEPTH);

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cmd_table_engine_if #(.DATA_W(DW), .DEPTH(DEPTH), .CMD_W(CW)) bus ();

    cmd_table_engine #(.DATA_W(DW), .DEPTH(DEPTH), .CMD_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    rsp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Response monitor: any handshake with nothing expected is an error.
    always @(negedge clk) begin
        if (reset && bus.result_valid && bus.result_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_rsp: got result %h err %b, expected no response", bus.result, bus.err);
            end else begin
                rsp_t r;
                r = exp_q.pop_front();
                chk("rsp_data", bus.result, r.data);
                chk1("rsp_err", bus.err, r.err);
            end
        end
    end

    task automatic wr(input int a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[AW-1:0];
        bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL cmd_ready_timeout: got cmd_ready=0 for 50 cycles, expected 1");
        end
    endtask

    task automatic issue(input logic [CW-1:0] c, input logic e, input logic [DW-1:0] d,
                         input bit coll = 1'b0, input int ca = 0, input logic [DW-1:0] cd = '0);
        bit   ok;
        rsp_t r;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        wait_ready(ok);
        if (!ok) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        r.err  = e;
        r.data = d;
        exp_q.push_back(r);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (coll) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ca[AW-1:0];
            bus.wr_data = cd;
        end
        @(negedge clk);
        chk1("process_no_valid", bus.result_valid, 1'b0);
        chk1("process_busy", bus.busy, 1'b1);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        chk1("valid_at_2_cycles", bus.result_valid, 1'b1);
        if (bus.result_ready) begin
            @(negedge clk);
            chk1("valid_one_cycle", bus.result_valid, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.cmd_valid    = 1'b0;
        bus.cmd          = '0;
        bus.result_ready = 1'b1;

        // Check the outputs in reset, then check cmd_ready on the first cycle after release.
        #2;
        chk1("rst_valid", bus.result_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk("rst_result", bus.result, '0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        @(negedge clk);
        chk1("ready_after_reset", bus.cmd_ready, 1'b1);

        wr(3, 32'hDEADBEEF);
        issue(8'h03, 1'b0, 32'hDEADBEEF);

        // Accumulator wrap, then clear.
        wr(1, 32'hFFFF_FFFF);
        wr(2, 32'h0000_0002);
        issue(8'h41, 1'b0, 32'hFFFF_FFFF);
        issue(8'h42, 1'b0, 32'h0000_0001);
        issue(8'h80, 1'b0, 32'h0000_0000);

        // Backpressure: hold DONE while a second command is waiting.
        wr(4, 32'h0000_1234);
        bus.result_ready = 1'b0;
        issue(8'h04, 1'b0, 32'h0000_1234);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = 8'h03;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_valid_held", bus.result_valid, 1'b1);
            chk("bp_result_held", bus.result, 32'h0000_1234);
            chk1("bp_err_held", bus.err, 1'b0);
            chk1("bp_no_ready", bus.cmd_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.result_ready = 1'b1;
        @(negedge clk);
        chk1("bp_no_accept_before_drain", bus.cmd_ready, 1'b0);
        issue(8'h03, 1'b0, 32'hDEADBEEF);

        // Error cases, the index boundary, and checks that acc is left unchanged.
        wr(11, 32'hB0B0_B0B0);
        issue(8'h41, 1'b0, 32'hFFFF_FFFF);
        issue(8'hC1, 1'b1, 32'h0);
        issue(8'h42, 1'b0, 32'h0000_0001);
        issue(8'h0D, 1'b1, 32'h0);
        issue(8'h4D, 1'b1, 32'h0);
        issue(8'h0C, 1'b1, 32'h0);
        issue(8'h0B, 1'b0, 32'hB0B0_B0B0);
        issue(8'h42, 1'b0, 32'h0000_0003);

        // A NOP is consumed silently.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("nop_ready", bus.cmd_ready, 1'b1);
            chk1("nop_busy", bus.busy, 1'b0);
            chk1("nop_no_valid", bus.result_valid, 1'b0);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;

        // A write in the PROCESS cycle does not affect the read in flight.
        wr(5, 32'hAAAA_0005);
        issue(8'h05, 1'b0, 32'hAAAA_0005, 1'b1, 5, 32'h0000_0055);
        issue(8'h05, 1'b0, 32'h0000_0055);

        // Reset asserted during PROCESS aborts the command.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd       = 8'h43;
        wait_ready(ok);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk1("async_rst_busy", bus.busy, 1'b0);
        chk1("async_rst_valid", bus.result_valid, 1'b0);
        chk("async_rst_result", bus.result, '0);
        chk1("async_rst_err", bus.err, 1'b0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        @(negedge clk);
        chk1("ready_after_midop_reset", bus.cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("no_rsp_after_abort", bus.result_valid, 1'b0);
        end
        issue(8'h44, 1'b0, 32'h0000_1234);
        issue(8'h03, 1'b0, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
